izh_dw_sequencer: RTL and testbench
===================================

IZH_DW_SEQUENCER -- requirements
Module: izh_dw_sequencer

Interface
REQ-001 SHALL have parameter N, default 20, total fixed-point word width in bits.
REQ-002 SHALL have parameter Q, default 10, number of fractional bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an operand set is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 SHALL have ports a, b, d, v, w and step, each input, N bits, signed two's complement Q-format: model parameters, membrane potential, recovery variable and time step.
REQ-008 SHALL have port spike, input, 1 bit: the spike flag that selects the reset path.
REQ-009 SHALL have port out_valid, output, 1 bit: a result is present.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port w_out, output, N bits: the updated recovery variable.
REQ-012 SHALL have port dw_out, output, N bits: the increment applied to w.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL compute dw = a*((b*v) - w)*step using exactly one shared N x N multiplier, time-multiplexed.
REQ-015 Each multiply SHALL form the signed 2N-bit product, arithmetic-shift it right by Q (floor), and keep the low N bits, subject to REQ-025 and REQ-026.
REQ-016 Operands SHALL be registered on the accept edge (in_valid and in_ready both high); later changes to the inputs SHALL have no effect on the result.
REQ-017 The FSM SHALL have states IDLE, MUL_BV, MUL_A, MUL_STEP, ADD and DONE.
REQ-018 On the accept edge: if spike=0 the FSM SHALL go to MUL_BV; if spike=1 it SHALL go to ADD with dw set to d.
REQ-019 MUL_BV SHALL compute t = b*v - w, then go to MUL_A; MUL_A SHALL compute t = a*t, then go to MUL_STEP; MUL_STEP SHALL compute dw = t*step, then go to ADD; ADD SHALL compute w_out = w + dw, then go to DONE. Each state SHALL last exactly one cycle.
REQ-020 in_ready SHALL equal (state == IDLE), and the block SHALL hold no second operand set.
REQ-021 out_valid SHALL equal (state == DONE): 5 cycles after the accept edge when spike=0, 2 cycles after it when spike=1.
REQ-022 In DONE, w_out and dw_out SHALL hold stable until out_ready is high; on that edge the FSM SHALL return to IDLE. in_ready SHALL rise in the following cycle, with no same-cycle bypass.
REQ-023 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.

Reset
REQ-024 rst_n low SHALL immediately force the state to IDLE and clear w_out, dw_out, out_valid, busy and all internal registers to 0; in_ready SHALL be 1. This SHALL hold in any state, including mid-sequence, and the in-flight operation SHALL be discarded without producing a result.

Configuration
REQ-025 With macro IZH_DW_SAT_EN defined, every multiply and add result outside the range [-2^(N-1), 2^(N-1)-1] SHALL clamp to the nearest bound.
REQ-026 Without IZH_DW_SAT_EN, results SHALL wrap modulo 2^N (two's complement truncation).

Verification (N=20, Q=10, 1.0 = 1024)
REQ-027 Unity case: a=b=step=1024, v=2048, w=1024, spike=0 -> out_valid 5 cycles after accept, dw_out=1024, w_out=2048.
REQ-028 Izhikevich case: a=20, b=205, v=-66560, w=-13312, step=102, spike=0 -> dw_out=-1, w_out=-13313.
REQ-029 Spike path: w=1024, d=8192, spike=1 -> out_valid 2 cycles after accept, dw_out=8192, w_out=9216; the multiplier is not used.
REQ-030 Backpressure: hold out_ready low for 3 cycles in DONE -> outputs stable, in_ready=0 and busy=1 throughout; raise out_ready -> IDLE, in_ready=1 on the next cycle.
REQ-031 Overflow: w=524000, d=1024, spike=1 -> w_out=524287 with IZH_DW_SAT_EN, w_out=-523552 without it.
REQ-032 Reset mid-operation: assert rst_n low while in MUL_A -> immediate IDLE, outputs 0, no out_valid pulse; a fresh accept after release gives the REQ-027 result.

Source files
------------

// File: rtl/izh_dw_sequencer.sv
// Izhikevich recovery-variable update dw = a*((b*v) - w)*step on one shared multiplier.
// Define IZH_DW_SAT_EN to clamp every multiply/add result; otherwise results wrap.
module izh_dw_sequencer #(
    parameter int N = 20,
    parameter int Q = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    input  logic signed [N-1:0] d,
    input  logic signed [N-1:0] v,
    input  logic signed [N-1:0] w,
    input  logic signed [N-1:0] step,
    input  logic                spike,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] w_out,
    output logic signed [N-1:0] dw_out,
    output logic                busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL_BV   = 3'd1,
        MUL_A    = 3'd2,
        MUL_STEP = 3'd3,
        ADD      = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic signed [2*N-1:0] MAX_EXT = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [2*N-1:0] MIN_EXT = {{(N+1){1'b1}}, {(N-1){1'b0}}};

    state_t               state_reg;
    logic signed [N-1:0]  a_reg, b_reg, v_reg, w_reg, step_reg;
    logic signed [N-1:0]  t_reg, dw_reg, w_out_reg;
    logic                 in_ready_reg, out_valid_reg, busy_reg;

    logic signed [N-1:0]   mul_x, mul_y;
    logic signed [2*N-1:0] prod, prod_shift;
    logic signed [N-1:0]   mul_res, sub_res, add_res;

    function automatic logic signed [2*N-1:0] ext(input logic signed [N-1:0] x);
        return {{N{x[N-1]}}, x};
    endfunction

    // Reduce a wide intermediate to N bits: clamp or two's complement wrap.
    function automatic logic signed [N-1:0] fit(input logic signed [2*N-1:0] x);
`ifdef IZH_DW_SAT_EN
        if (x > MAX_EXT)
            return MAX_EXT[N-1:0];
        else if (x < MIN_EXT)
            return MIN_EXT[N-1:0];
        else
            return x[N-1:0];
`else
        return x[N-1:0];
`endif
    endfunction

    // Operand steering for the single multiplier.
    always_comb begin
        mul_x = b_reg;
        mul_y = v_reg;
        case (state_reg)
            MUL_A: begin
                mul_x = a_reg;
                mul_y = t_reg;
            end
            MUL_STEP: begin
                mul_x = t_reg;
                mul_y = step_reg;
            end
            default: ;
        endcase
    end

    assign prod       = ext(mul_x) * ext(mul_y);
    assign prod_shift = prod >>> Q;
    assign mul_res    = fit(prod_shift);
    assign sub_res    = fit(ext(mul_res) - ext(w_reg));
    assign add_res    = fit(ext(w_reg) + ext(dw_reg));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            v_reg         <= '0;
            w_reg         <= '0;
            step_reg      <= '0;
            t_reg         <= '0;
            dw_reg        <= '0;
            w_out_reg     <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        v_reg        <= v;
                        w_reg        <= w;
                        step_reg     <= step;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        if (spike) begin
                            dw_reg    <= d;
                            state_reg <= ADD;
                        end else begin
                            state_reg <= MUL_BV;
                        end
                    end
                end
                MUL_BV: begin
                    t_reg     <= sub_res;
                    state_reg <= MUL_A;
                end
                MUL_A: begin
                    t_reg     <= mul_res;
                    state_reg <= MUL_STEP;
                end
                MUL_STEP: begin
                    dw_reg    <= mul_res;
                    state_reg <= ADD;
                end
                ADD: begin
                    w_out_reg     <= add_res;
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign w_out     = w_out_reg;
    assign dw_out    = dw_reg;

endmodule

// File: tb/tb_izh_dw_sequencer.sv
// Self-checking bench for izh_dw_sequencer: per-cycle model compare plus literal expectations.
// Honours IZH_DW_SAT_EN for the overflow expectations.
module tb_izh_dw_sequencer;

    localparam int N = 20;
    localparam int Q = 10;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] a, b, d, v, w, step;
    logic                spike;
    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] w_out, dw_out;
    logic                busy;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    izh_dw_sequencer #(.N(N), .Q(Q)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .d         (d),
        .v         (v),
        .w         (w),
        .step      (step),
        .spike     (spike),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .w_out     (w_out),
        .dw_out    (dw_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference arithmetic: exact integer maths, then clamp or wrap to N bits.
    function automatic longint fitm(input longint x);
        longint lim;
        longint m;
        lim = longint'(1) <<< (N - 1);
`ifdef IZH_DW_SAT_EN
        if (x > lim - 1) return lim - 1;
        if (x < -lim) return -lim;
        return x;
`else
        m = x & ((longint'(1) <<< N) - 1);
        if (m >= lim) m = m - (longint'(1) <<< N);
        return m;
`endif
    endfunction

    function automatic longint mulq(input longint x, input longint y);
        return fitm((x * y) >>> Q);
    endfunction

    // Model: one pending result, due a fixed number of cycles after acceptance.
    initial begin
        bit     pending;
        bit     eo;
        int     due;
        int     ncyc;
        longint ew, edw, t;
        pending = 1'b0;
        due = 0;
        ew = 0;
        edw = 0;
        forever begin
            @(negedge clk);
            ncyc = cyc;
            eo = 1'b0;
            if (!rst_n) begin
                pending = 1'b0;
                chk("rst in_ready", in_ready, 1);
                chk("rst out_valid", out_valid, 0);
                chk("rst busy", busy, 0);
                chk("rst w_out", w_out, 0);
                chk("rst dw_out", dw_out, 0);
            end else begin
                eo = pending && (ncyc >= due);
                chk("model in_ready", in_ready, !pending);
                chk("model busy", busy, pending);
                chk("model out_valid", out_valid, eo);
                if (eo) begin
                    chk("model w_out", w_out, ew);
                    chk("model dw_out", dw_out, edw);
                end
            end
            @(posedge clk);
            if (rst_n) begin
                if (!pending && in_valid) begin
                    pending = 1'b1;
                    if (spike) begin
                        due = ncyc + 2;
                        edw = d;
                    end else begin
                        due = ncyc + 5;
                        t   = fitm(mulq(b, v) - w);
                        t   = mulq(a, t);
                        edw = mulq(t, step);
                    end
                    ew = fitm(longint'(w) + edw);
                end else if (eo && out_ready) begin
                    pending = 1'b0;
                end
            end
        end
    end

    task automatic xact(input string tag, input int ia, input int ib, input int id,
                        input int iv, input int iw, input int istep, input bit ispk,
                        input int hold, input int exp_lat, input longint exp_w,
                        input longint exp_dw);
        int acc;
        int got;
        @(posedge clk);
        #1;
        a = N'(ia); b = N'(ib); d = N'(id); v = N'(iv); w = N'(iw); step = N'(istep);
        spike = ispk;
        in_valid = 1'b1;
        out_ready = 1'b0;
        acc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            chk({tag, " accept timeout"}, 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = N'($urandom); b = N'($urandom); d = N'($urandom);
        v = N'($urandom); w = N'($urandom); step = N'($urandom);
        spike = 1'($urandom);
        got = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                got = cyc;
                break;
            end
        end
        if (got < 0) begin
            chk({tag, " out_valid timeout"}, 0, 1);
            return;
        end
        chk({tag, " latency"}, got - acc, exp_lat);
        chk({tag, " w_out"}, w_out, exp_w);
        chk({tag, " dw_out"}, dw_out, exp_dw);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, " in_ready after release"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; d = '0; v = '0; w = '0; step = '0;
        spike = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        xact("unity", 1024, 1024, 0, 2048, 1024, 1024, 1'b0, 0, 5, 2048, 1024);
        xact("izh", 20, 205, 0, -66560, -13312, 102, 1'b0, 0, 5, -13313, -1);
        xact("spike", 777, -33, 8192, 4096, 1024, 99, 1'b1, 0, 2, 9216, 8192);
        xact("backpressure", 1024, 1024, 0, 2048, 1024, 1024, 1'b0, 3, 5, 2048, 1024);
        xact("negative", 1024, 512, 0, -3072, 512, 512, 1'b0, 1, 5, -512, -1024);
`ifdef IZH_DW_SAT_EN
        xact("add overflow", 0, 0, 1024, 0, 524000, 0, 1'b1, 0, 2, 524287, 1024);
        xact("mul overflow", 1024, 4096, 0, 262144, 0, 1024, 1'b0, 0, 5, 524287, 524287);
`else
        xact("add overflow", 0, 0, 1024, 0, 524000, 0, 1'b1, 0, 2, -523552, 1024);
        xact("mul overflow", 1024, 4096, 0, 262144, 0, 1024, 1'b0, 0, 5, 0, 0);
`endif

        // Reset while the sequence sits in its second multiply.
        @(posedge clk);
        #1;
        a = 1024; b = 1024; v = 2048; w = 1024; step = 1024; d = 0; spike = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("midrst busy before", busy, 1);
        chk("midrst in_ready before", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst in_ready", in_ready, 1);
        chk("midrst busy", busy, 0);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst w_out", w_out, 0);
        chk("midrst dw_out", dw_out, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst no result", out_valid, 0);
        xact("after reset", 1024, 1024, 0, 2048, 1024, 1024, 1'b0, 0, 5, 2048, 1024);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
